// File: rtl/dcache_pkg.sv
// Shared types and default sizing for the direct-mapped write-through data cache.
package dcache_pkg;

   localparam int unsigned DefNbits  = 8;
   localparam int unsigned DefNlines = 4;

   typedef enum logic [1:0] {
      StIdle,
      StRmiss,
      StWthru,
      StDone
   } state_e;

endpackage

// File: rtl/dcache_tagarray.sv
// Per-line valid/tag/data storage: one combinational read port, one write port, sync clear.
module dcache_tagarray #(
   parameter int unsigned NLINES = 4,
   parameter int unsigned IDXW   = 2,
   parameter int unsigned TAGW   = 4,
   parameter int unsigned NBITS  = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [IDXW-1:0]  rd_idx_i,
   output logic             rd_valid_o,
   output logic [TAGW-1:0]  rd_tag_o,
   output logic [NBITS-1:0] rd_data_o,
   input  logic             we_i,
   input  logic [IDXW-1:0]  wr_idx_i,
   input  logic [TAGW-1:0]  wr_tag_i,
   input  logic [NBITS-1:0] wr_data_i
);

   logic             valid_q [NLINES];
   logic [TAGW-1:0]  tag_q   [NLINES];
   logic [NBITS-1:0] data_q  [NLINES];

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_data_o  = data_q[rd_idx_i];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NLINES; i++) begin
            valid_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            data_q[i]  <= '0;
         end
      end else if (we_i) begin
         valid_q[wr_idx_i] <= 1'b1;
         tag_q[wr_idx_i]   <= wr_tag_i;
         data_q[wr_idx_i]  <= wr_data_i;
      end
   end

endmodule

// File: rtl/dcache.sv
// Direct-mapped, one-word-line, write-through / no-write-allocate data cache with
// a single outstanding backing-memory transaction and saturating load hit/miss counters.
module dcache
   import dcache_pkg::*;
#(
   parameter int unsigned NBITS  = DefNbits,
   parameter int unsigned NLINES = DefNlines
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [NBITS-3:0] Address,
   input  logic [NBITS-1:0] WriteData,
   input  logic             MemRead,
   input  logic             MemWrite,
   output logic [NBITS-1:0] ReadData,
   output logic             Stall,
   output logic             mem_req,
   output logic             mem_we,
   output logic [NBITS-3:0] mem_addr,
   output logic [NBITS-1:0] mem_wdata,
   input  logic [NBITS-1:0] mem_rdata,
   input  logic             mem_ack,
   output logic [15:0]      hit_count,
   output logic [15:0]      miss_count
);

   localparam int unsigned IdxW = $clog2(NLINES);
   localparam int unsigned TagW = NBITS - 2 - IdxW;

   state_e           state_q;
   logic             mem_req_q, mem_we_q;
   logic [NBITS-3:0] mem_addr_q;
   logic [NBITS-1:0] mem_wdata_q;
   logic [15:0]      hit_q, miss_q;

   logic [IdxW-1:0]  rd_idx;
   logic             line_valid;
   logic [TagW-1:0]  line_tag;
   logic [NBITS-1:0] line_data;
   logic             load_req, hit, miss, ta_we;
   logic [NBITS-1:0] ta_wdata;

   // While a transaction is outstanding the line of interest is the one being filled/written.
   assign rd_idx = (state_q == StIdle) ? Address[IdxW-1:0] : mem_addr_q[IdxW-1:0];

   dcache_tagarray #(
      .NLINES(NLINES),
      .IDXW  (IdxW),
      .TAGW  (TagW),
      .NBITS (NBITS)
   ) u_tagarray (
      .clock     (clock),
      .reset     (reset),
      .rd_idx_i  (rd_idx),
      .rd_valid_o(line_valid),
      .rd_tag_o  (line_tag),
      .rd_data_o (line_data),
      .we_i      (ta_we),
      .wr_idx_i  (mem_addr_q[IdxW-1:0]),
      .wr_tag_i  (mem_addr_q[NBITS-3:IdxW]),
      .wr_data_i (ta_wdata)
   );

   always_comb begin
      load_req = MemRead & ~MemWrite;
      hit      = (state_q == StIdle) & load_req & line_valid
                 & (line_tag == Address[NBITS-3:IdxW]);
      miss     = (state_q == StIdle) & load_req & ~hit;
      ReadData = hit ? line_data : '0;
      ta_we    = 1'b0;
      ta_wdata = mem_rdata;
      Stall    = 1'b0;
      unique case (state_q)
         StIdle:  Stall = MemWrite | miss;
         StRmiss: begin
            Stall = 1'b1;
            ta_we = mem_ack;
         end
         StWthru: begin
            Stall    = 1'b1;
            ta_wdata = mem_wdata_q;
            ta_we    = mem_ack & line_valid & (line_tag == mem_addr_q[NBITS-3:IdxW]);
         end
         StDone:  Stall = 1'b0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StIdle;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         hit_q       <= '0;
         miss_q      <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (MemWrite) begin
                  mem_addr_q  <= Address;
                  mem_wdata_q <= WriteData;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b1;
                  state_q     <= StWthru;
               end else if (miss) begin
                  mem_addr_q <= Address;
                  mem_req_q  <= 1'b1;
                  mem_we_q   <= 1'b0;
                  state_q    <= StRmiss;
                  if (miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
               end else if (hit) begin
                  if (hit_q != 16'hFFFF) hit_q <= hit_q + 16'd1;
               end
            end
            StRmiss: begin
               if (mem_ack) begin
                  mem_req_q <= 1'b0;
                  state_q   <= StIdle;
               end
            end
            StWthru: begin
               if (mem_ack) begin
                  mem_req_q <= 1'b0;
                  state_q   <= StDone;
               end
            end
            StDone: state_q <= StIdle;
         endcase
      end
   end

   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign hit_count  = hit_q;
   assign miss_count = miss_q;

endmodule

// File: tb/tb_dcache.sv
// Table-driven bench for dcache with a behavioural backing memory and a read-data scoreboard.
module tb_dcache;

   localparam int Lat = 3;

   logic       clock, reset;
   logic [5:0] Address;
   logic [7:0] WriteData;
   logic       MemRead, MemWrite;
   logic [7:0] ReadData;
   logic       Stall;
   logic       mem_req, mem_we;
   logic [5:0] mem_addr;
   logic [7:0] mem_wdata, mem_rdata;
   logic       mem_ack;
   logic [15:0] hit_count, miss_count;

   dcache #(
      .NBITS (8),
      .NLINES(4)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .Address   (Address),
      .WriteData (WriteData),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .ReadData  (ReadData),
      .Stall     (Stall),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .hit_count (hit_count),
      .miss_count(miss_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic       rd;
      logic       wr;
      logic [5:0] addr;
      logic [7:0] wdata;
      int         exp_stalls;
      logic [7:0] exp_rdata;
      int         exp_hits;
      int         exp_misses;
      int         exp_writes;
   } vec_t;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] mem [64];
   int         mem_cnt  = 0;
   int         n_writes = 0;
   bit         auto_mem = 1'b1;
   logic [7:0] exp_q [$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   // Backing memory: acks on the Lat-th cycle that mem_req is seen high.
   task automatic mem_step();
      if (!auto_mem) return;
      if (!mem_req || mem_ack) begin
         mem_ack   = 1'b0;
         mem_rdata = 8'h00;
         mem_cnt   = 0;
      end else begin
         mem_cnt++;
         if (mem_cnt == Lat) begin
            mem_ack = 1'b1;
            if (mem_we) begin
               mem[mem_addr] = mem_wdata;
               n_writes++;
            end else begin
               mem_rdata = mem[mem_addr];
            end
         end
      end
   endtask

   // Starts at posedge+1; holds the request until Stall drops, as a stalled pipeline would.
   task automatic cpu_op(input logic rd, input logic wr, input logic [5:0] addr,
                         input logic [7:0] wdata, output int stalls);
      bit         done;
      logic [7:0] got, exp;
      MemRead   = rd;
      MemWrite  = wr;
      Address   = addr;
      WriteData = wdata;
      stalls    = 0;
      done      = 1'b0;
      got       = 8'h00;
      for (int c = 0; c < 50; c++) begin
         @(negedge clock);
         if (!Stall) begin
            got  = ReadData;
            done = 1'b1;
            break;
         end
         stalls++;
         if (mem_req) begin
            check("mem_addr", {26'd0, mem_addr}, {26'd0, addr});
            check("mem_we", {31'd0, mem_we}, {31'd0, wr});
            if (wr) check("mem_wdata", {24'd0, mem_wdata}, {24'd0, wdata});
         end
         @(posedge clock);
         #1 mem_step();
      end
      if (!done) check("stall_timeout", 32'd1, 32'd0);
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         exp = exp_q.pop_front();
         check("ReadData", {24'd0, got}, {24'd0, exp});
      end
      @(posedge clock);
      #1 mem_step();
      MemRead  = 1'b0;
      MemWrite = 1'b0;
   endtask

   initial begin
      vec_t vecs [15];
      int   stalls;

      vecs[0]  = '{1'b0, 1'b0, 6'h00, 8'h00, 0, 8'h00, 0, 0, 0};
      vecs[1]  = '{1'b1, 1'b0, 6'h05, 8'h00, 4, 8'h3C, 1, 1, 0};
      vecs[2]  = '{1'b1, 1'b0, 6'h05, 8'h00, 0, 8'h3C, 2, 1, 0};
      vecs[3]  = '{1'b0, 1'b1, 6'h05, 8'hA5, 4, 8'h00, 2, 1, 1};
      vecs[4]  = '{1'b1, 1'b0, 6'h05, 8'h00, 0, 8'hA5, 3, 1, 1};
      vecs[5]  = '{1'b1, 1'b0, 6'h01, 8'h00, 4, 8'h38, 4, 2, 1};
      vecs[6]  = '{1'b1, 1'b0, 6'h05, 8'h00, 4, 8'hA5, 5, 3, 1};
      vecs[7]  = '{1'b1, 1'b0, 6'h01, 8'h00, 4, 8'h38, 6, 4, 1};
      vecs[8]  = '{1'b0, 1'b1, 6'h10, 8'h5A, 4, 8'h00, 6, 4, 2};
      vecs[9]  = '{1'b1, 1'b0, 6'h10, 8'h00, 4, 8'h5A, 7, 5, 2};
      vecs[10] = '{1'b1, 1'b1, 6'h02, 8'h77, 4, 8'h00, 7, 5, 3};
      vecs[11] = '{1'b1, 1'b0, 6'h02, 8'h00, 4, 8'h77, 8, 6, 3};
      vecs[12] = '{1'b1, 1'b0, 6'h10, 8'h00, 0, 8'h5A, 9, 6, 3};
      vecs[13] = '{1'b0, 1'b1, 6'h10, 8'hC3, 4, 8'h00, 9, 6, 4};
      vecs[14] = '{1'b1, 1'b0, 6'h10, 8'h00, 0, 8'hC3, 10, 6, 4};

      for (int i = 0; i < 64; i++) mem[i] = 8'(i) ^ 8'h39;
      reset     = 1'b1;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      Address   = '0;
      WriteData = '0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      check("rst_Stall", {31'd0, Stall}, 32'd0);
      check("rst_ReadData", {24'd0, ReadData}, 32'd0);
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_mem_addr", {26'd0, mem_addr}, 32'd0);
      check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
      check("rst_hits", {16'd0, hit_count}, 32'd0);
      check("rst_misses", {16'd0, miss_count}, 32'd0);

      for (int i = 0; i < 15; i++) begin
         exp_q.push_back(vecs[i].exp_rdata);
         cpu_op(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, stalls);
         check($sformatf("v%0d_stalls", i), stalls, vecs[i].exp_stalls);
         check($sformatf("v%0d_hits", i), {16'd0, hit_count}, vecs[i].exp_hits);
         check($sformatf("v%0d_misses", i), {16'd0, miss_count}, vecs[i].exp_misses);
         check($sformatf("v%0d_writes", i), n_writes, vecs[i].exp_writes);
      end

      // Reset while a read miss is outstanding; the late ack must be ignored.
      auto_mem = 1'b0;
      MemRead  = 1'b1;
      Address  = 6'h07;
      @(negedge clock);
      check("rmiss_stall", {31'd0, Stall}, 32'd1);
      @(posedge clock);
      #1 check("rmiss_req", {31'd0, mem_req}, 32'd1);
      @(posedge clock);
      #1 reset = 1'b1;
      MemRead = 1'b0;
      @(posedge clock);
      #1 reset = 1'b0;
      check("mrst_mem_req", {31'd0, mem_req}, 32'd0);
      check("mrst_mem_addr", {26'd0, mem_addr}, 32'd0);
      check("mrst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
      check("mrst_hits", {16'd0, hit_count}, 32'd0);
      check("mrst_misses", {16'd0, miss_count}, 32'd0);
      check("mrst_Stall", {31'd0, Stall}, 32'd0);
      mem_ack   = 1'b1;
      mem_rdata = 8'hEE;
      @(posedge clock);
      #1 mem_ack = 1'b0;
      mem_rdata = 8'h00;
      check("late_ack_req", {31'd0, mem_req}, 32'd0);
      check("late_ack_Stall", {31'd0, Stall}, 32'd0);
      mem_cnt  = 0;
      auto_mem = 1'b1;

      exp_q.push_back(8'h3E);
      cpu_op(1'b1, 1'b0, 6'h07, 8'h00, stalls);
      check("post_rst_stalls", stalls, 4);
      check("post_rst_misses", {16'd0, miss_count}, 32'd1);
      check("post_rst_hits", {16'd0, hit_count}, 32'd1);
      exp_q.push_back(8'hC3);
      cpu_op(1'b1, 1'b0, 6'h10, 8'h00, stalls);
      check("post_rst_cleared_stalls", stalls, 4);
      check("post_rst_cleared_misses", {16'd0, miss_count}, 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
